// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit with HI/LO registers and a fixed-latency busy window.
// Optional: define MDU_MADD_EN to enable md_op=7 (madd, 64-bit multiply-accumulate into {hi,lo}).
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_MADD  = 3'd7
    } op_e;

    typedef enum logic {IDLE, RUN} state_e;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES + 1) : 1;

    state_e        state, state_next;
    logic [CW-1:0] cnt;
    op_e           op_in, op_q;
    logic [31:0]   a_q, b_q;
    logic          launch;
    logic          is_div_in;
    logic          res_we;
    logic [31:0]   res_hi, res_lo;
    logic [63:0]   prod_s, prod_u;

    assign op_in = op_e'(md_op);
    assign busy  = (state == RUN);

    always_comb begin
        launch    = 1'b0;
        is_div_in = 1'b0;
        case (op_in)
            OP_MULT, OP_MULTU: launch = start;
            OP_DIV, OP_DIVU: begin
                launch    = start;
                is_div_in = 1'b1;
            end
`ifdef MDU_MADD_EN
            OP_MADD: launch = start;
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (launch) state_next = RUN;
            RUN:  if (cnt == CW'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Result is formed from the latched operands; divide by zero suppresses the write.
    always_comb begin
        res_we = 1'b0;
        res_hi = hi;
        res_lo = lo;
        case (op_q)
            OP_MULT: begin
                res_we = 1'b1;
                {res_hi, res_lo} = prod_s;
            end
            OP_MULTU: begin
                res_we = 1'b1;
                {res_hi, res_lo} = prod_u;
            end
            OP_DIV: begin
                if (b_q != '0) begin
                    res_we = 1'b1;
                    if (a_q == 32'h8000_0000 && b_q == '1) begin
                        res_lo = 32'h8000_0000;
                        res_hi = '0;
                    end else begin
                        res_lo = 32'($signed(a_q) / $signed(b_q));
                        res_hi = 32'($signed(a_q) % $signed(b_q));
                    end
                end
            end
            OP_DIVU: begin
                if (b_q != '0) begin
                    res_we = 1'b1;
                    res_lo = a_q / b_q;
                    res_hi = a_q % b_q;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                res_we = 1'b1;
                {res_hi, res_lo} = {hi, lo} + prod_s;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            op_q <= OP_NONE;
            a_q  <= '0;
            b_q  <= '0;
            hi   <= '0;
            lo   <= '0;
        end else if (state == IDLE) begin
            if (launch) begin
                op_q <= op_in;
                a_q  <= rs_data;
                b_q  <= rt_data;
                cnt  <= is_div_in ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end else if (start && op_in == OP_MTHI) begin
                hi <= rs_data;
            end else if (start && op_in == OP_MTLO) begin
                lo <= rs_data;
            end
        end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1) && res_we) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against an arithmetic reference model.
// Define MDU_MADD_EN for both files to exercise madd.
module tb_mult_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        busy;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: remaining busy cycles plus the pending operation, evaluated arithmetically.
    logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
    int          m_rem = 0;
    int          m_op = 0;

    task automatic model_commit();
        int          sa, sb;
        longint      ps, q, r;
        longint unsigned pu;
        logic [63:0] acc;
        sa = m_a;
        sb = m_b;
        case (m_op)
            1: begin ps = longint'(sa) * longint'(sb); {m_hi, m_lo} = ps; end
            2: begin pu = longint'(m_a) * longint'(m_b); {m_hi, m_lo} = pu; end
            3: if (m_b != 0) begin
                q = longint'(sa) / longint'(sb);
                r = longint'(sa) % longint'(sb);
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            4: if (m_b != 0) begin m_lo = m_a / m_b; m_hi = m_a % m_b; end
            7: begin
                ps  = longint'(sa) * longint'(sb);
                acc = {m_hi, m_lo} + ps;
                {m_hi, m_lo} = acc;
            end
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; m_rem = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) model_commit();
        end else if (start) begin
            case (md_op)
                3'd1, 3'd2: begin m_op = md_op; m_a = rs_data; m_b = rt_data; m_rem = MULT_N; end
                3'd3, 3'd4: begin m_op = md_op; m_a = rs_data; m_b = rt_data; m_rem = DIV_N; end
                3'd5: m_hi = rs_data;
                3'd6: m_lo = rs_data;
`ifdef MDU_MADD_EN
                3'd7: begin m_op = 7; m_a = rs_data; m_b = rt_data; m_rem = MULT_N; end
`endif
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", {31'd0, busy}, {31'd0, m_rem > 0});
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        md_op = op; rs_data = a; rt_data = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            rs_data = $urandom;
            rt_data = $urandom;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        issue(3'd1, 32'hFFFF_FFFD, 32'd7);
        wait_idle(n);
        check("mult_cycles", n, MULT_N);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);
        check("model_mult_lo", m_lo, 32'hFFFF_FFEB);

        issue(3'd4, 32'd100, 32'd7);
        wait_idle(n);
        check("divu_cycles", n, DIV_N);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        check("model_div_hi", m_hi, 32'hFFFF_FFFF);

        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'd0);

        issue(3'd5, 32'h1234, 32'd0);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        issue(3'd6, 32'h5678, 32'd0);
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        issue(3'd3, 32'd5, 32'd0);
        wait_idle(n);
        check("divz_cycles", n, DIV_N);
        check("divz_hi", hi, 32'h1234);
        check("divz_lo", lo, 32'h5678);

        issue(3'd0, 32'hDEAD_BEEF, 32'd3);
        check("none_busy", {31'd0, busy}, 32'd0);
        check("none_hi", hi, 32'h1234);

        // div in flight, multu request at busy cycle 2, reset at busy cycle 3
        issue(3'd4, 32'd100, 32'd7);
        md_op = 3'd2; rs_data = 32'd9; rt_data = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        repeat (15) @(negedge clk);
        check("abort_late_hi", hi, 32'd0);
        check("abort_late_lo", lo, 32'd0);

        issue(3'd6, 32'd10, 32'd0);
        issue(3'd7, 32'd2, 32'd3);
        wait_idle(n);
`ifdef MDU_MADD_EN
        check("madd_cycles", n, MULT_N);
        check("madd_lo", lo, 32'd16);
        check("madd_hi", hi, 32'd0);
`else
        check("op7_cycles", n, 0);
        check("op7_lo", lo, 32'd10);
        check("op7_hi", hi, 32'd0);
`endif

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            md_op = 3'($urandom_range(0, 7));
            rs_data = pick();
            rt_data = pick();
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n = 0;
            while (busy && n < 40) begin
                rs_data = $urandom;
                rt_data = $urandom;
                if ($urandom_range(0, 7) == 0) begin
                    md_op = 3'($urandom_range(0, 7));
                    start = 1'b1;
                end
                if ($urandom_range(0, 59) == 0) reset = 1'b1;
                @(negedge clk);
                start = 1'b0;
                reset = 1'b0;
                n++;
            end
            check("rand_timeout", {31'd0, n < 40}, 32'd1);
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
